// File: rtl/sprite_writer.sv
// Sprite writer: streams pixels from a valid/ready source into sprite memory.
// Latency: an accepted pixel appears on mem_we_o/mem_addr_o/mem_data_o one cycle later.
// Backpressure: pix_ready_o is high only while loading; mem writes are never stalled.
// Optional build macro: SPRITE_WRITER_SKIP_TRANSPARENT_EN (pixel value 0 consumes a slot but is not written).
module sprite_writer #(
    parameter int DEPTH  = 1536,
    parameter int ADDR_W = 11,
    parameter int PIX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] length_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_data_i,
    output logic              pix_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [PIX_W-1:0]  mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] count_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  data_q, data_d;

    logic              accept;
    logic              write_en;

    // Reset asserts immediately but releases on a clock edge so the FSM leaves reset cleanly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign pix_ready_o = (state_q == S_LOAD);
    assign accept      = pix_valid_i && pix_ready_o;

`ifdef SPRITE_WRITER_SKIP_TRANSPARENT_EN
    // Transparent pixels still advance pointer and count, they just leave memory untouched.
    assign write_en = accept && (pix_data_i != '0);
`else
    assign write_en = accept;
`endif

    // Next-state logic: FSM, write pointer with DEPTH wrap, saturating pixel count, write register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = length_i;
                    ptr_d   = base_addr_i;
                    count_d = '0;
                    state_d = (length_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d   = write_en;
                    addr_d = ptr_q;
                    data_d = pix_data_i;
                    ptr_d  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ONE;
                    if (count_q != len_q) begin
                        count_d = count_q + ONE;
                    end
                    if (count_q + ONE == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign count_o    = count_q;

endmodule

// File: tb/tb_sprite_writer.sv
// Directed bench for sprite_writer with a write scoreboard.
// Inputs are driven on falling edges; outputs are sampled on falling edges.
// Expected writes are queued when a pixel is driven and popped by the write monitor.
module tb_sprite_writer;

    localparam int ADDR_W = 11;
    localparam int PIX_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] len = '0;
    logic              pix_valid = 1'b0;
    logic [PIX_W-1:0]  pix_data = '0;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int w0;

    logic [ADDR_W+PIX_W-1:0] exp_q[$];

    sprite_writer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .base_addr_i (base),
        .length_i    (len),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .pix_ready_o (pix_ready),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .busy_o      (busy),
        .done_o      (done),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_exp(input int a, input int d);
        exp_q.push_back({ADDR_W'(a), PIX_W'(d)});
    endtask

    // Called on a falling edge; returns on the next falling edge with start dropped.
    task automatic do_start(input int b, input int l);
        start = 1'b1;
        base  = ADDR_W'(b);
        len   = ADDR_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int d);
        pix_valid = 1'b1;
        pix_data  = PIX_W'(d);
        @(negedge clk);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    initial begin
        logic [ADDR_W+PIX_W-1:0] e;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                wr_cnt++;
                check("write_expected", (exp_q.size() != 0), 1);
                check("addr_in_range", (mem_addr < 11'd1536), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e[ADDR_W+PIX_W-1:PIX_W]);
                    check("wr_data", mem_data, e[PIX_W-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", pix_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // Basic load: base 0, four pixels back-to-back
        w0 = wr_cnt;
        do_start(0, 4);
        check("t1_ready", pix_ready, 1);
        check("t1_busy", busy, 1);
        check("t1_count_clr", count, 0);
        for (int i = 1; i <= 4; i++) begin
            push_exp(i - 1, i);
            send(i);
        end
        pix_valid = 1'b0;
        check("t1_done", done, 1);
        check("t1_ready_off", pix_ready, 0);
        check("t1_count", count, 4);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_writes", wr_cnt - w0, 4);
        check("t1_count_hold", count, 4);

        // Pointer wraps at DEPTH, not at 2^ADDR_W
        w0 = wr_cnt;
        do_start(1534, 4);
        push_exp(1534, 9);  send(9);
        push_exp(1535, 10); send(10);
        push_exp(0, 11);    send(11);
        push_exp(1, 12);    send(12);
        pix_valid = 1'b0;
        check("t2_done", done, 1);
        @(negedge clk);
        check("t2_writes", wr_cnt - w0, 4);

        // Zero-length load completes with no pixel traffic
        w0 = wr_cnt;
        pix_valid = 1'b1;
        pix_data  = 4'd3;
        do_start(7, 0);
        check("t3_done", done, 1);
        check("t3_ready", pix_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_count", count, 0);
        @(negedge clk);
        check("t3_done_pulse", done, 0);
        check("t3_ready2", pix_ready, 0);
        pix_valid = 1'b0;
        @(negedge clk);
        check("t3_writes", wr_cnt - w0, 0);

        // Gapped valid 1,0,0,1,1 with a restart attempt in the gap
        w0 = wr_cnt;
        do_start(100, 3);
        push_exp(100, 3); send(3);
        pix_valid = 1'b0;
        pix_data  = 4'd15;
        start = 1'b1; base = 11'd500; len = 11'd7;
        @(negedge clk);
        start = 1'b0;
        check("t4_gap_busy", busy, 1);
        @(negedge clk);
        check("t4_gap_count", count, 1);
        push_exp(101, 4); send(4);
        push_exp(102, 5); send(5);
        pix_valid = 1'b0;
        check("t4_done", done, 1);
        check("t4_count", count, 3);
        @(negedge clk);
        check("t4_writes", wr_cnt - w0, 3);
        check("t4_idle", busy, 0);

        // Reset during a load abandons it
        w0 = wr_cnt;
        do_start(200, 8);
        push_exp(200, 1); send(1);
        push_exp(201, 2); send(2);
        pix_valid = 1'b1;
        pix_data  = 4'd6;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ready", pix_ready, 0);
        check("t5_rst_we", mem_we, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_data", mem_data, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_writes", wr_cnt - w0, 2);
        check("t5_idle_ready", pix_ready, 0);
        pix_valid = 1'b0;
        do_start(300, 2);
        push_exp(300, 8); send(8);
        push_exp(301, 9); send(9);
        pix_valid = 1'b0;
        check("t5_done", done, 1);
        check("t5_count", count, 2);
        @(negedge clk);
        check("t5_writes", wr_cnt - w0, 4);

        // Transparent pixel handling
        w0 = wr_cnt;
        do_start(50, 3);
        push_exp(50, 5); send(5);
`ifndef SPRITE_WRITER_SKIP_TRANSPARENT_EN
        push_exp(51, 0);
`endif
        send(0);
        push_exp(52, 7); send(7);
        pix_valid = 1'b0;
        check("t6_done", done, 1);
        check("t6_count", count, 3);
        @(negedge clk);
`ifdef SPRITE_WRITER_SKIP_TRANSPARENT_EN
        check("t6_writes", wr_cnt - w0, 2);
`else
        check("t6_writes", wr_cnt - w0, 3);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
